// File: rtl/l2_line_adaptor_pkg.sv
// Shared types and constants for the L2 line adaptor: line/beat geometry,
// FSM state encoding and the line-alignment helper.
package l2_line_adaptor_pkg;

   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;
   localparam int BEATS  = LINE_W / BEAT_W;
   localparam int CNT_W  = $clog2(BEATS);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} l2_adaptor_state_t;

   typedef logic [LINE_W-1:0] line_t;
   typedef logic [BEAT_W-1:0] beat_t;

   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return {addr[31:5], 5'b0};
   endfunction

endpackage

// File: rtl/l2_line_adaptor_if.sv
// L2 pmem request/response bus and off-chip burst bus seen by the adaptor.
// The adaptor takes the slave view; L2 plus burst memory together form the master.
interface l2_line_adaptor_if;
   import l2_line_adaptor_pkg::*;

   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_address;
   line_t       pmem_wdata;
   logic        pmem_resp;
   line_t       pmem_rdata;

   logic        burst_read;
   logic        burst_write;
   logic [31:0] burst_address;
   beat_t       burst_wdata;
   logic        burst_resp;
   beat_t       burst_rdata;

   logic        timeout_err;

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_resp, pmem_rdata,
      output burst_read, burst_write, burst_address, burst_wdata,
      input  burst_resp, burst_rdata,
      output timeout_err
   );

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_resp, pmem_rdata,
      input  burst_read, burst_write, burst_address, burst_wdata,
      output burst_resp, burst_rdata,
      input  timeout_err
   );

endinterface

// File: rtl/l2_line_adaptor_line_beat_buffer.sv
// One cache line of storage: whole-line load, clear, beat-indexed write and
// beat-indexed read mux. Single-cycle write, combinational read.
module line_beat_buffer
   import l2_line_adaptor_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  line_t            load_line,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_idx,
   input  beat_t            wr_beat,
   input  logic [CNT_W-1:0] rd_idx,
   output beat_t            rd_beat,
   output line_t            line
);

   line_t line_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else if (load) begin
         line_q <= load_line;
      end else if (clr) begin
         line_q <= '0;
      end else if (wr_en) begin
         line_q[wr_idx*BEAT_W +: BEAT_W] <= wr_beat;
      end
   end

   assign rd_beat = line_q[rd_idx*BEAT_W +: BEAT_W];
   assign line    = line_q;

endmodule

// File: rtl/l2_line_adaptor.sv
// Turns each 256-bit L2 line request into a 4-beat 64-bit burst; pmem_resp 5 cycles after the request
// with zero-wait memory, beats stall on burst_resp. L2_LINE_ADAPTOR_TIMEOUT_EN adds a per-beat watchdog.
module l2_line_adaptor
   import l2_line_adaptor_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic              clk,
   input logic              rst_n,
   l2_line_adaptor_if.slave bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("l2_line_adaptor: TIMEOUT_CYCLES must be at least 1");
   end

   l2_adaptor_state_t state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              rd_op_q;
   logic              pmem_resp_q;
   logic              burst_read_q;
   logic              burst_write_q;
   logic [31:0]       addr_q;
   line_t             rdata_hold_q;
   line_t             line_q;
   beat_t             rd_beat;

   logic accept_wr;
   logic accept_rd;
   logic beat_vld;
   logic last_beat;
   logic expire;

   // Write wins when both requests are high.
   assign accept_wr = (state_q == IDLE) && bus.pmem_write;
   assign accept_rd = (state_q == IDLE) && !bus.pmem_write && bus.pmem_read;
   assign beat_vld  = ((state_q == RD) || (state_q == WR)) && bus.burst_resp;
   assign last_beat = beat_vld && (cnt_q == CNT_W'(BEATS - 1));

   line_beat_buffer u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept_wr),
      .load_line (bus.pmem_wdata),
      .clr       (accept_rd),
      .wr_en     (beat_vld && (state_q == RD)),
      .wr_idx    (cnt_q),
      .wr_beat   (bus.burst_rdata),
      .rd_idx    (cnt_q),
      .rd_beat   (rd_beat),
      .line      (line_q)
   );

`ifdef L2_LINE_ADAPTOR_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WAIT_W-1:0] wait_q;
   logic              timeout_err_q;

   assign expire = ((state_q == RD) || (state_q == WR)) && !bus.burst_resp &&
                   (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q        <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (((state_q != RD) && (state_q != WR)) || bus.burst_resp) begin
            wait_q <= '0;
         end else begin
            wait_q <= wait_q + 1'b1;
         end
         if (expire) begin
            timeout_err_q <= 1'b1;
         end
      end
   end

   assign bus.timeout_err = timeout_err_q;
`else
   assign expire          = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rd_op_q       <= 1'b0;
         pmem_resp_q   <= 1'b0;
         burst_read_q  <= 1'b0;
         burst_write_q <= 1'b0;
         addr_q        <= '0;
         rdata_hold_q  <= '0;
      end else begin
         pmem_resp_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (accept_wr) begin
                  state_q       <= WR;
                  rd_op_q       <= 1'b0;
                  burst_write_q <= 1'b1;
                  addr_q        <= line_align(bus.pmem_address);
               end else if (accept_rd) begin
                  state_q      <= RD;
                  rd_op_q      <= 1'b1;
                  burst_read_q <= 1'b1;
                  addr_q       <= line_align(bus.pmem_address);
               end
            end
            RD, WR: begin
               if (last_beat || expire) begin
                  state_q       <= DONE;
                  cnt_q         <= '0;
                  burst_read_q  <= 1'b0;
                  burst_write_q <= 1'b0;
                  pmem_resp_q   <= 1'b1;
               end else if (beat_vld) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               // Never re-accept here: a request still high belongs to the line just completed.
               state_q <= IDLE;
               if (rd_op_q) begin
                  rdata_hold_q <= line_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pmem_resp     = pmem_resp_q;
   assign bus.pmem_rdata    = ((state_q == DONE) && rd_op_q) ? line_q : rdata_hold_q;
   assign bus.burst_read    = burst_read_q;
   assign bus.burst_write   = burst_write_q;
   assign bus.burst_address = addr_q;
   assign bus.burst_wdata   = burst_write_q ? rd_beat : '0;

   a_rw_both : assert property (@(posedge clk) disable iff (!rst_n)
      !((state_q == IDLE) && bus.pmem_read && bus.pmem_write))
      else $warning("l2_line_adaptor: pmem_read and pmem_write both high in IDLE, write taken");

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Bench for l2_line_adaptor: directed vector table, corner-case sequences and random
// line traffic against a burst memory model and a line-level reference model.
module tb_l2_line_adaptor;
   import l2_line_adaptor_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   l2_line_adaptor_if bus();

   l2_line_adaptor #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Burst memory model: one beat per high burst_resp, mem_gap idle cycles between beats,
   // optionally goes silent after stall_after beats.
   beat_t rd_beats[$];
   beat_t wr_seen[$];
   int    mem_gap     = 0;
   int    stall_after = -1;
   int    gap_left    = 0;
   int    beats_given = 0;
   line_t last_rd     = '0;

   always @(negedge clk) begin
      if (!rst_n || !(bus.burst_read || bus.burst_write)) begin
         bus.burst_resp = 1'b0;
         gap_left       = 0;
         beats_given    = 0;
      end else if (gap_left > 0) begin
         bus.burst_resp = 1'b0;
         gap_left--;
      end else if (stall_after >= 0 && beats_given >= stall_after) begin
         bus.burst_resp = 1'b0;
      end else begin
         bus.burst_resp = 1'b1;
         if (rd_beats.size() > 0) bus.burst_rdata = rd_beats.pop_front();
         else                     bus.burst_rdata = {$urandom, $urandom};
         if (bus.burst_write) wr_seen.push_back(bus.burst_wdata);
         beats_given++;
         gap_left = mem_gap;
      end
   end

   task automatic chk(input string nm, input line_t act, input line_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic line_t rand_line();
      line_t r = '0;
      for (int i = 0; i < LINE_W / 32; i++) r = {r[LINE_W-33:0], $urandom};
      return r;
   endfunction

   function automatic beat_t slice_of(input line_t l, input int i);
      return beat_t'(l >> (BEAT_W * i));
   endfunction

   task automatic chk_write_beats(input string tag, input line_t data);
      chk({tag, " wr_beat_count"}, line_t'(wr_seen.size()), line_t'(BEATS));
      for (int i = 0; i < BEATS && i < wr_seen.size(); i++)
         chk($sformatf("%s wr_beat%0d", tag, i), line_t'(wr_seen[i]), line_t'(slice_of(data, i)));
   endtask

   // One full line transaction; memory returns data's slices low to high for reads.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input line_t data, input int gap,
                          input int exp_lat, input logic [31:0] exp_addr, input string tag);
      int lat = 0;
      @(negedge clk);
      mem_gap     = gap;
      stall_after = -1;
      rd_beats.delete();
      wr_seen.delete();
      if (!wr) for (int i = 0; i < BEATS; i++) rd_beats.push_back(slice_of(data, i));
      bus.pmem_address = addr;
      bus.pmem_wdata   = wr ? data : rand_line();
      bus.pmem_write   = wr;
      bus.pmem_read    = !wr;
      for (int k = 1; k <= 300 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk({tag, " burst_level"}, line_t'({bus.burst_write, bus.burst_read}), line_t'(wr ? 2'b10 : 2'b01));
            chk({tag, " burst_address"}, line_t'(bus.burst_address), line_t'(exp_addr));
            bus.pmem_address = ~addr;
            bus.pmem_wdata   = ~data;
         end
         if (bus.pmem_resp) lat = k;
      end
      chk({tag, " resp_latency"}, line_t'(lat), line_t'(exp_lat));
      chk({tag, " burst_off_in_done"}, line_t'({bus.burst_write, bus.burst_read}), '0);
      if (wr) begin
         chk_write_beats(tag, data);
         chk({tag, " rdata_held"}, bus.pmem_rdata, last_rd);
      end else begin
         chk({tag, " rdata"}, bus.pmem_rdata, data);
         last_rd = data;
      end
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
      @(negedge clk);
      chk({tag, " resp_one_cycle"}, line_t'(bus.pmem_resp), '0);
      chk({tag, " timeout_err"}, line_t'(bus.timeout_err), '0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      line_t       data;
      int          gap;
      int          exp_lat;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      line_t w2;
      line_t b0_line;
      beat_t b0;
      int    lat;
      bit    seen;

      vecs[0] = '{1'b0, 32'h0000_1234,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 5, 32'h0000_1220};
      vecs[1] = '{1'b1, 32'h8000_0040,
                  {64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978,
                   64'h8877_6655_4433_2211, 64'h0000_0000_0000_0123}, 0, 5, 32'h8000_0040};
      vecs[2] = '{1'b0, 32'h0000_1000,
                  {64'hA5A5_0000_FFFF_0004, 64'hA5A5_0000_FFFF_0003,
                   64'hA5A5_0000_FFFF_0002, 64'hA5A5_0000_FFFF_0001}, 3, 14, 32'h0000_1000};
      vecs[3] = '{1'b1, 32'h1234_567F,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 1, 8, 32'h1234_5660};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF,
                  {64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000}, 0, 5, 32'hFFFF_FFE0};
      vecs[5] = '{1'b0, 32'h0000_001F,
                  {64'h1357_9BDF_2468_ACE0, 64'hC0DE_C0DE_C0DE_C0DE,
                   64'h0000_FFFF_0000_FFFF, 64'hBEEF_0000_0000_BEEF}, 2, 11, 32'h0000_0000};

      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      bus.burst_resp   = 1'b0;
      bus.burst_rdata  = '0;

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset ctrl", line_t'({bus.pmem_resp, bus.burst_read, bus.burst_write, bus.timeout_err}), '0);
      chk("reset pmem_rdata", bus.pmem_rdata, '0);
      chk("reset burst_address", line_t'(bus.burst_address), '0);
      chk("reset burst_wdata", line_t'(bus.burst_wdata), '0);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].gap,
                 vecs[i].exp_lat, vecs[i].exp_addr, $sformatf("vec%0d", i));

      // Both requests high: write wins, request held through DONE must not restart a burst.
      @(negedge clk);
      rd_beats.delete();
      wr_seen.delete();
      mem_gap          = 0;
      w2               = rand_line();
      bus.pmem_address = 32'h0000_0100;
      bus.pmem_wdata   = w2;
      bus.pmem_read    = 1'b1;
      bus.pmem_write   = 1'b1;
      lat              = 0;
      for (int k = 1; k <= 100 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) chk("both burst_level", line_t'({bus.burst_write, bus.burst_read}), line_t'(2'b10));
         if (bus.pmem_resp) lat = k;
      end
      chk("both resp_latency", line_t'(lat), line_t'(5));
      chk("both burst_off_in_done", line_t'({bus.burst_write, bus.burst_read}), '0);
      chk_write_beats("both", w2);
      @(negedge clk);
      chk("both idle_no_burst", line_t'({bus.burst_write, bus.burst_read, bus.pmem_resp}), '0);
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
      @(negedge clk);
      chk("both no_reaccept", line_t'({bus.burst_write, bus.burst_read}), '0);

      // Reset after two read beats: abandon the burst, no response.
      @(negedge clk);
      rd_beats.delete();
      mem_gap          = 0;
      bus.pmem_address = 32'h0000_2000;
      bus.pmem_read    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst ctrl", line_t'({bus.pmem_resp, bus.burst_read, bus.burst_write, bus.timeout_err}), '0);
      chk("midrst pmem_rdata", bus.pmem_rdata, '0);
      chk("midrst burst_address", line_t'(bus.burst_address), '0);
      chk("midrst burst_wdata", line_t'(bus.burst_wdata), '0);
      bus.pmem_read = 1'b0;
      last_rd       = '0;
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.pmem_resp || bus.burst_read) seen = 1'b1;
      end
      chk("midrst no_resp", line_t'(seen), '0);
      run_txn(1'b0, 32'h0000_2000, rand_line(), 0, 5, 32'h0000_2000, "post_reset");

      // Random traffic: expected latency is one request cycle, one cycle per beat and gap cycles between beats.
      for (int n = 0; n < 24; n++) begin
         bit          wr   = 1'($urandom_range(0, 1));
         logic [31:0] addr = $urandom;
         int          gap  = $urandom_range(0, 3);
         run_txn(wr, addr, rand_line(), gap, 1 + BEATS + gap * (BEATS - 1),
                 addr & 32'hFFFF_FFE0, $sformatf("rnd%0d", n));
      end

`ifdef L2_LINE_ADAPTOR_TIMEOUT_EN
      // Memory stalls after the first beat: watchdog completes the line after 16 silent cycles.
      @(negedge clk);
      rd_beats.delete();
      b0 = {$urandom, $urandom};
      rd_beats.push_back(b0);
      mem_gap          = 0;
      stall_after      = 1;
      bus.pmem_address = 32'h0000_3000;
      bus.pmem_read    = 1'b1;
      lat              = 0;
      for (int k = 1; k <= 200 && lat == 0; k++) begin
         @(negedge clk);
         if (bus.pmem_resp) lat = k;
      end
      b0_line = '0;
      b0_line[BEAT_W-1:0] = b0;
      chk("tmo resp_latency", line_t'(lat), line_t'(18));
      chk("tmo timeout_err", line_t'(bus.timeout_err), line_t'(1));
      chk("tmo rdata", bus.pmem_rdata, b0_line);
      bus.pmem_read = 1'b0;
      stall_after   = -1;
      repeat (3) @(negedge clk);
      chk("tmo sticky", line_t'(bus.timeout_err), line_t'(1));
      chk("tmo resp_one_cycle", line_t'(bus.pmem_resp), '0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
